// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder: address map constants,
// region and FSM enums, and the address-to-region decode helper.
// No ports; imported by cpu_bus_responder and joypad_shift.
package cpu_bus_pkg;

  // RAM occupies $0000-$1FFF: any address with addr[15:13] clear.
  localparam logic [15:0] RAM_MASK  = 16'hE000;
  localparam logic [15:0] PAD1_ADDR = 16'h4016;
  localparam logic [15:0] PAD2_ADDR = 16'h4017;
  localparam logic [15:0] ROM_BASE  = 16'h8000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PAD,
    REG_ROM,
    REG_NONE
  } region_e;

  typedef enum logic {
    IDLE,
    ROM_WAIT_ST
  } rsp_state_e;

  function automatic region_e decode_region(input logic [15:0] a);
    region_e r;
    if ((a & RAM_MASK) == 16'h0000) begin
      r = REG_RAM;
    end else if (a == PAD1_ADDR || a == PAD2_ADDR) begin
      r = REG_PAD;
    end else if ((a & ROM_BASE) != 16'h0000) begin
      r = REG_ROM;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_joypad_shift.sv
// Joypad serial port: 8-bit parallel-load shift register that fills with 1s.
// Ports: clk/reset (async high), strobe_i (reload every cycle while high),
//        rd_i (shift one bit out), par_i (button state), ser_o (current bit).
module joypad_shift
  import cpu_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe_i,
  input  logic       rd_i,
  input  logic [7:0] par_i,
  output logic       ser_o
);

  logic [7:0] shift_q;
  logic [7:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (strobe_i) begin
      shift_d = par_i;
    end else if (rd_i) begin
      // Shifting in 1s makes every read past the eighth return 1.
      shift_d = {1'b1, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= 8'hFF;
    end else begin
      shift_q <= shift_d;
    end
  end

  // While strobed the register is transparent, so button A is seen live.
  assign ser_o = strobe_i ? par_i[0] : shift_q[0];

endmodule

// File: rtl/cpu_bus_responder.sv
// 6502 bus responder: mirrored 2 KB RAM, two joypad ports, PRG-ROM window
// with ROM_WAIT wait states via ready, open-bus value for unmapped reads.
// Ports: clk, reset (async high), addr/write/wdata from CPU, rdata/ready to
//        CPU, pad1/pad2_buttons, rom_addr out, rom_data in.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_AW   = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        write,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam bit          ROM_NOWAIT = (ROM_WAIT == 0);
  localparam logic [3:0]  WAIT_LOAD  = (ROM_WAIT > 0) ? 4'(ROM_WAIT - 1) : 4'd0;

  rsp_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] open_bus_q, open_bus_d;
  logic       strobe_q, strobe_d;

  logic [7:0] mem_q [RAM_DEPTH];

  region_e            region;
  logic               accept;
  logic [RAM_AW-1:0]  ram_idx;
  logic               ram_we;
  logic               pad1_rd;
  logic               pad2_rd;
  logic               pad1_ser;
  logic               pad2_ser;
  logic               pad_bit;

  assign region  = decode_region(addr);
  // The CPU bus is only sampled while we are not stalling it.
  assign accept  = (state_q == IDLE);
  assign ram_idx = addr[RAM_AW-1:0];
  assign ram_we  = accept && write && (region == REG_RAM);
  assign pad1_rd = accept && !write && (region == REG_PAD) && !addr[0];
  assign pad2_rd = accept && !write && (region == REG_PAD) && addr[0];
  assign pad_bit = addr[0] ? pad2_ser : pad1_ser;

  joypad_shift u_pad1 (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (strobe_q),
    .rd_i     (pad1_rd),
    .par_i    (pad1_buttons),
    .ser_o    (pad1_ser)
  );

  joypad_shift u_pad2 (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (strobe_q),
    .rd_i     (pad2_rd),
    .par_i    (pad2_buttons),
    .ser_o    (pad2_ser)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    open_bus_d = open_bus_q;
    strobe_d   = strobe_q;
    unique case (state_q)
      IDLE: begin
        if (write) begin
          open_bus_d = wdata;
          unique case (region)
            REG_RAM: rdata_d = wdata;
            REG_PAD: if (!addr[0]) strobe_d = wdata[0];
            default: ;
          endcase
        end else begin
          unique case (region)
            REG_RAM: begin
              rdata_d    = mem_q[ram_idx];
              open_bus_d = mem_q[ram_idx];
            end
            REG_PAD: begin
              rdata_d    = {open_bus_q[7:5], 4'b0000, pad_bit};
              open_bus_d = {open_bus_q[7:5], 4'b0000, pad_bit};
            end
            REG_ROM: begin
              if (ROM_NOWAIT) begin
                rdata_d    = rom_data;
                open_bus_d = rom_data;
              end else begin
                // Bus value is only updated when the data is returned.
                state_d = ROM_WAIT_ST;
                cnt_d   = WAIT_LOAD;
              end
            end
            default: rdata_d = open_bus_q;
          endcase
        end
      end
      ROM_WAIT_ST: begin
        if (cnt_q == 4'd0) begin
          state_d    = IDLE;
          rdata_d    = rom_data;
          open_bus_d = rom_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 8'h00;
      open_bus_q <= 8'h00;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      open_bus_q <= open_bus_d;
      strobe_q   <= strobe_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= wdata;
    end
  end

  assign rdata    = rdata_q;
  assign ready    = (state_q == IDLE);
  assign rom_addr = addr[14:0];

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        write;
  logic [7:0]  wdata;
  logic [7:0]  rdata, rdata_nw;
  logic        ready, ready_nw;
  logic [7:0]  pad1, pad2;
  logic [14:0] rom_addr, rom_addr_nw;
  logic [7:0]  rom_data, rom_data_nw;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [14:0] a);
    if (a == 15'h0000) return 8'hA9;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  assign rom_data    = rom_val(rom_addr);
  assign rom_data_nw = rom_val(rom_addr_nw);

  cpu_bus_responder #(.ROM_WAIT(2), .RAM_AW(11)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write(write), .wdata(wdata),
    .rdata(rdata), .ready(ready), .pad1_buttons(pad1), .pad2_buttons(pad2),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  cpu_bus_responder #(.ROM_WAIT(0), .RAM_AW(11)) dut_nw (
    .clk(clk), .reset(reset), .addr(addr), .write(write), .wdata(wdata),
    .rdata(rdata_nw), .ready(ready_nw), .pad1_buttons(pad1), .pad2_buttons(pad2),
    .rom_addr(rom_addr_nw), .rom_data(rom_data_nw)
  );

  // Drives one access, returns after the data cycle (ready high again).
  task automatic bus_op(input logic [15:0] a, input logic w, input logic [7:0] d,
                        output int waits, output logic rdy_before);
    addr = a; write = w; wdata = d;
    rdy_before = ready;
    @(posedge clk); #1;
    waits = 0;
    while (!ready && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
  endtask

  task automatic test_reset();
    int w; logic rb;
    addr = 16'h5000; write = 1'b1; wdata = 8'h00; pad1 = 8'h00; pad2 = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (rdata !== 8'h00) begin failed++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    tests_run++;
    if (ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b expected 1", ready); end
    reset = 1'b0;
    bus_op(16'h4016, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h01) begin failed++; $display("FAIL reset_pad_ff: got %h expected 01", rdata); end
  endtask

  task automatic test_ram_mirror();
    int w; logic rb;
    bus_op(16'h0123, 1'b1, 8'h5A, w, rb);
    tests_run++;
    if (rdata !== 8'h5A || ready !== 1'b1) begin
      failed++; $display("FAIL ram_write_through: got %h/%b expected 5a/1", rdata, ready);
    end
    bus_op(16'h0923, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h5A || rb !== 1'b1 || w != 0) begin
      failed++; $display("FAIL ram_mirror_0923: got %h rdy %b waits %0d expected 5a 1 0", rdata, rb, w);
    end
    bus_op(16'h1923, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h5A) begin failed++; $display("FAIL ram_mirror_1923: got %h expected 5a", rdata); end
  endtask

  task automatic test_pad_shift();
    int w; logic rb;
    logic [8:0] seq;
    logic [7:0] p2v;
    seq = 9'b1_1000_0001;
    pad1 = 8'b1000_0001; pad2 = 8'h6A;
    p2v = pad2;
    bus_op(16'h4016, 1'b1, 8'h01, w, rb);
    bus_op(16'h4016, 1'b1, 8'h00, w, rb);
    for (int i = 0; i < 9; i++) begin
      bus_op(16'h4016, 1'b0, 8'h00, w, rb);
      tests_run++;
      if (rdata !== {7'b0, seq[i]}) begin
        failed++; $display("FAIL pad1_shift_%0d: got %h expected %h", i, rdata, {7'b0, seq[i]});
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus_op(16'h4017, 1'b0, 8'h00, w, rb);
      tests_run++;
      if (rdata !== {7'b0, p2v[i]}) begin
        failed++; $display("FAIL pad2_shift_%0d: got %h expected %h", i, rdata, {7'b0, p2v[i]});
      end
    end
  endtask

  task automatic test_pad_strobe();
    int w; logic rb;
    logic [2:0] live;
    live = 3'b101;
    pad1 = 8'h00; pad2 = 8'hFE;
    bus_op(16'h4016, 1'b1, 8'h01, w, rb);
    for (int i = 0; i < 3; i++) begin
      pad1[0] = live[i];
      bus_op(16'h4016, 1'b0, 8'h00, w, rb);
      tests_run++;
      if (rdata !== {7'b0, live[i]}) begin
        failed++; $display("FAIL pad1_live_%0d: got %h expected %h", i, rdata, {7'b0, live[i]});
      end
    end
    bus_op(16'h4017, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h00) begin failed++; $display("FAIL pad2_live: got %h expected 00", rdata); end
    // Drop strobe: pad2 must start from bit 0 of FE, not shifted.
    bus_op(16'h4016, 1'b1, 8'h00, w, rb);
    bus_op(16'h4017, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h00) begin failed++; $display("FAIL pad2_after_strobe0: got %h expected 00", rdata); end
    bus_op(16'h4017, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h01) begin failed++; $display("FAIL pad2_after_strobe1: got %h expected 01", rdata); end
    bus_op(16'h4016, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h01) begin failed++; $display("FAIL pad1_after_strobe: got %h expected 01", rdata); end
  endtask

  task automatic test_rom_wait();
    int waits; logic rb;
    addr = 16'h8000; write = 1'b0; wdata = 8'h00;
    @(posedge clk); #1;
    tests_run++;
    if (ready !== 1'b0) begin failed++; $display("FAIL rom_ready_low: got %b expected 0", ready); end
    tests_run++;
    if (rdata_nw !== 8'hA9 || ready_nw !== 1'b1) begin
      failed++; $display("FAIL rom_nowait: got %h/%b expected a9/1", rdata_nw, ready_nw);
    end
    waits = 1;
    while (!ready && waits < 40) begin
      @(posedge clk); #1;
      if (!ready) waits++;
    end
    tests_run++;
    if (waits != 2 || rdata !== 8'hA9) begin
      failed++; $display("FAIL rom_wait2: got waits %0d data %h expected 2 a9", waits, rdata);
    end
    bus_op(16'hC123, 1'b0, 8'h00, waits, rb);
    tests_run++;
    if (waits != 2 || rdata !== rom_val(15'h4123)) begin
      failed++; $display("FAIL rom_c123: got waits %0d data %h expected 2 %h", waits, rdata, rom_val(15'h4123));
    end
  endtask

  task automatic test_open_bus();
    int w; logic rb;
    bus_op(16'h0040, 1'b1, 8'h3C, w, rb);
    bus_op(16'h0040, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h3C) begin failed++; $display("FAIL ob_ram_read: got %h expected 3c", rdata); end
    bus_op(16'h5000, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h3C) begin failed++; $display("FAIL ob_unmapped_1: got %h expected 3c", rdata); end
    bus_op(16'h6000, 1'b1, 8'h77, w, rb);
    tests_run++;
    if (rdata !== 8'h3C) begin failed++; $display("FAIL ob_unmapped_wr_hold: got %h expected 3c", rdata); end
    bus_op(16'h5000, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h77) begin failed++; $display("FAIL ob_unmapped_2: got %h expected 77", rdata); end
  endtask

  task automatic test_reset_mid_wait();
    int w; logic rb;
    addr = 16'h8000; write = 1'b0; wdata = 8'h00;
    @(posedge clk); #1;
    tests_run++;
    if (ready !== 1'b0) begin failed++; $display("FAIL midwait_enter: got %b expected 0", ready); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (ready !== 1'b1 || rdata !== 8'h00) begin
      failed++; $display("FAIL midwait_reset: got %b/%h expected 1/00", ready, rdata);
    end
    #2 reset = 1'b0;
    bus_op(16'h0123, 1'b0, 8'h00, w, rb);
    tests_run++;
    if (rdata !== 8'h5A || rb !== 1'b1 || w != 0) begin
      failed++; $display("FAIL midwait_ram_after: got %h rdy %b waits %0d expected 5a 1 0", rdata, rb, w);
    end
  endtask

  // Reference model: RAM contents, open-bus byte, strobe, and per-pad
  // latched buttons plus count of bits already read.
  logic [7:0] m_ram [2048];
  bit         m_vld [2048];

  task automatic test_random();
    int w; logic rb;
    logic [7:0]  m_ob, m_rd, d, bt;
    logic [15:0] a;
    logic [7:0]  m_latch [2];
    int          m_cnt [2];
    bit          m_strobe;
    int          sel, p, idx;
    logic        bitv;
    addr = 16'h5000; write = 1'b1; wdata = 8'h00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ob = 8'h00; m_rd = 8'h00; m_strobe = 1'b0;
    m_cnt[0] = 8; m_cnt[1] = 8; m_latch[0] = 8'hFF; m_latch[1] = 8'hFF;
    for (int i = 0; i < 2048; i++) m_vld[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin pad1 = 8'($urandom); pad2 = 8'($urandom); end
      if (m_strobe) begin
        m_latch[0] = pad1; m_latch[1] = pad2; m_cnt[0] = 0; m_cnt[1] = 0;
      end
      sel = $urandom_range(0, 9);
      d = 8'($urandom);
      idx = $urandom_range(0, 2047);
      if ((sel == 2 || sel == 3) && !m_vld[idx]) sel = 0;
      case (sel)
        0, 1: begin
          a = 16'($urandom_range(0, 16'h1FFF));
          m_ram[a[10:0]] = d; m_vld[a[10:0]] = 1'b1;
          m_rd = d; m_ob = d;
          bus_op(a, 1'b1, d, w, rb);
        end
        2, 3: begin
          a = {3'b000, 2'($urandom), idx[10:0]};
          m_rd = m_ram[idx]; m_ob = m_rd;
          bus_op(a, 1'b0, 8'h00, w, rb);
        end
        4: begin
          p = $urandom_range(0, 1);
          bt = p ? pad2 : pad1;
          if (m_strobe) bitv = bt[0];
          else begin
            bt = m_latch[p];
            bitv = (m_cnt[p] < 8) ? bt[m_cnt[p]] : 1'b1;
            if (m_cnt[p] < 8) m_cnt[p]++;
          end
          m_rd = {m_ob[7:5], 4'b0000, bitv}; m_ob = m_rd;
          bus_op(p ? 16'h4017 : 16'h4016, 1'b0, 8'h00, w, rb);
        end
        5: begin
          m_ob = d; m_strobe = d[0];
          bus_op(16'h4016, 1'b1, d, w, rb);
        end
        6: begin
          m_ob = d;
          bus_op(16'h4017, 1'b1, d, w, rb);
        end
        7: begin
          a = 16'($urandom_range(16'h2000, 16'h7FFF));
          if (a == 16'h4016 || a == 16'h4017) a = 16'h5000;
          if (d[7]) begin m_ob = d; bus_op(a, 1'b1, d, w, rb); end
          else begin m_rd = m_ob; bus_op(a, 1'b0, 8'h00, w, rb); end
        end
        8: begin
          a = {1'b1, 15'($urandom)};
          m_rd = rom_val(a[14:0]); m_ob = m_rd;
          bus_op(a, 1'b0, 8'h00, w, rb);
          tests_run++;
          if (w != 2) begin failed++; $display("FAIL rand_rom_waits_%0d: got %0d expected 2", n, w); end
        end
        default: begin
          m_ob = d;
          bus_op({1'b1, 15'($urandom)}, 1'b1, d, w, rb);
        end
      endcase
      tests_run++;
      if (rdata !== m_rd) begin
        failed++; $display("FAIL rand_op_%0d sel %0d: got %h expected %h", n, sel, rdata, m_rd);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_ram_mirror();
    test_pad_shift();
    test_pad_strobe();
    test_rom_wait();
    test_open_bus();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
